// File: rtl/ripemd160_compress.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ripemd160_compress
// Description : RIPEMD-160 compression engine. Runs the left and right lines
//               for all 80 steps, UNROLL steps per clock, and then applies the
//               feed-forward into the chaining value. Blocks chain either
//               from the IV (i_first=1) or from the previous o_digest.
// Ports       : clk, rst_n (async, active-low)
//               i_valid/i_ready - block handshake (ready only when idle)
//               i_first         - 1: chain from IV, 0: chain from o_digest
//               i_block[511:0]  - X[j] = i_block[32j+31:32j]
//               o_valid         - one-cycle pulse, o_digest just updated
//               o_digest[159:0] - {h0,h1,h2,h3,h4}, held until next o_valid
// Revision    : 1.0 - initial release
// ============================================================================
module ripemd160_compress #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic         i_first,
    input  logic [511:0] i_block,
    output logic         o_valid,
    output logic [159:0] o_digest
);

    localparam logic [159:0] c_IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe,
                                     32'h10325476, 32'hc3d2e1f0};

    // Step tables, one nibble per step, step 0 in the most significant nibble.
    localparam logic [319:0] c_RL = 320'h0123456789abcdef_74d1a6f3c0952eb8_3ae49f812706db5c_19ba08c4d37fe562_40597c2ae138b6fd;
    localparam logic [319:0] c_RR = 320'h5e7092b4d6f81a3c_6b370d5aef8c4912_f5137e69b8c2a04d_86413bf05c2d97ae_cfa4158762de039b;
    localparam logic [319:0] c_SL = 320'hbefc5879bdef6798_768db97f7cf9b7dc_bd67e9dfe8d65c75_bcefef989e56865c_9f5b68dc5cdeb856;
    localparam logic [319:0] c_SR = 320'h899bdff5778beec6_9df7c89b77c76fdb_97fb866ecd5edd75_f58bee6e69c9c5f8_85c9c5e68d65fdbb;

    localparam bit c_UNROLL_OK = (UNROLL == 1)  || (UNROLL == 2)  || (UNROLL == 4)  ||
                                 (UNROLL == 5)  || (UNROLL == 8)  || (UNROLL == 10) ||
                                 (UNROLL == 16) || (UNROLL == 20);

    generate
        if (!c_UNROLL_OK) begin : g_bad_unroll
            $error("ripemd160_compress: UNROLL must be one of 1,2,4,5,8,10,16,20");
        end
    endgenerate

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ROUNDS = 1'b1} state_t;

    function automatic logic [31:0] f_rol(input logic [31:0] x, input logic [4:0] s);
        logic [63:0] t;
        t = {x, x} << s;
        return t[63:32];
    endfunction

    function automatic logic [31:0] f_bool(input logic [2:0] rnd, input logic [31:0] x,
                                           input logic [31:0] y, input logic [31:0] z);
        case (rnd)
            3'd0:    return x ^ y ^ z;
            3'd1:    return (x & y) | (~x & z);
            3'd2:    return (x | ~y) ^ z;
            3'd3:    return (x & z) | (y & ~z);
            default: return x ^ (y | ~z);
        endcase
    endfunction

    function automatic logic [31:0] f_kl(input logic [2:0] rnd);
        case (rnd)
            3'd0:    return 32'h00000000;
            3'd1:    return 32'h5a827999;
            3'd2:    return 32'h6ed9eba1;
            3'd3:    return 32'h8f1bbcdc;
            default: return 32'ha953fd4e;
        endcase
    endfunction

    function automatic logic [31:0] f_kr(input logic [2:0] rnd);
        case (rnd)
            3'd0:    return 32'h50a28be6;
            3'd1:    return 32'h5c4dd124;
            3'd2:    return 32'h6d703ef3;
            3'd3:    return 32'h7a6d76e9;
            default: return 32'h00000000;
        endcase
    endfunction

    function automatic logic [3:0] f_nib(input logic [319:0] tbl, input logic [6:0] j);
        return tbl[(9'd316 - {j, 2'b00}) +: 4];
    endfunction

    function automatic logic [31:0] f_word(input logic [511:0] x, input logic [3:0] idx);
        return x[{idx, 5'b00000} +: 32];
    endfunction

    state_t         state_q, state_d;
    logic [6:0]     j_q, j_d;
    logic [511:0]   x_q, x_d;
    logic [159:0]   c_q, c_d;        // chaining value latched at accept
    logic [159:0]   ll_q, ll_d;      // left line  {a,b,c,d,e}
    logic [159:0]   lr_q, lr_d;      // right line {a,b,c,d,e}
    logic [159:0]   digest_q, digest_d;
    logic           valid_q, valid_d;

    logic [31:0]    w_al, w_bl, w_cl, w_dl, w_el;
    logic [31:0]    w_ar, w_br, w_cr, w_dr, w_er;
    logic [31:0]    w_tl, w_tr;
    logic [6:0]     w_j;
    logic [2:0]     w_rnd;
    logic [159:0]   w_chain;
    logic [159:0]   w_ff;

    // UNROLL steps of both lines as one combinational chain.
    always_comb begin : p_chain
        {w_al, w_bl, w_cl, w_dl, w_el} = ll_q;
        {w_ar, w_br, w_cr, w_dr, w_er} = lr_q;
        w_j   = j_q;
        w_rnd = 3'd0;
        w_tl  = 32'd0;
        w_tr  = 32'd0;
        for (int u = 0; u < UNROLL; u++) begin
            w_j   = j_q + 7'(u);
            w_rnd = w_j[6:4];
            w_tl  = f_rol(w_al + f_bool(w_rnd, w_bl, w_cl, w_dl) +
                          f_word(x_q, f_nib(c_RL, w_j)) + f_kl(w_rnd),
                          {1'b0, f_nib(c_SL, w_j)}) + w_el;
            w_al  = w_el;
            w_el  = w_dl;
            w_dl  = f_rol(w_cl, 5'd10);
            w_cl  = w_bl;
            w_bl  = w_tl;
            // Right line runs the boolean functions in reverse round order.
            w_tr  = f_rol(w_ar + f_bool(3'd4 - w_rnd, w_br, w_cr, w_dr) +
                          f_word(x_q, f_nib(c_RR, w_j)) + f_kr(w_rnd),
                          {1'b0, f_nib(c_SR, w_j)}) + w_er;
            w_ar  = w_er;
            w_er  = w_dr;
            w_dr  = f_rol(w_cr, 5'd10);
            w_cr  = w_br;
            w_br  = w_tr;
        end
    end

    assign w_chain = i_first ? c_IV : digest_q;

    // Feed-forward from the chain output of the final step group.
    assign w_ff = {c_q[127:96]  + w_cl + w_dr,
                   c_q[95:64]   + w_dl + w_er,
                   c_q[63:32]   + w_el + w_ar,
                   c_q[31:0]    + w_al + w_br,
                   c_q[159:128] + w_bl + w_cr};

    always_comb begin : p_next
        state_d  = state_q;
        j_d      = j_q;
        x_d      = x_q;
        c_d      = c_q;
        ll_d     = ll_q;
        lr_d     = lr_q;
        digest_d = digest_q;
        valid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    x_d     = i_block;
                    c_d     = w_chain;
                    ll_d    = w_chain;
                    lr_d    = w_chain;
                    j_d     = 7'd0;
                    state_d = ST_ROUNDS;
                end
            end
            ST_ROUNDS: begin
                ll_d = {w_al, w_bl, w_cl, w_dl, w_el};
                lr_d = {w_ar, w_br, w_cr, w_dr, w_er};
                if (j_q + 7'(UNROLL) == 7'd80) begin
                    j_d      = 7'd0;
                    digest_d = w_ff;
                    valid_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    j_d = j_q + 7'(UNROLL);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            j_q      <= 7'd0;
            x_q      <= '0;
            c_q      <= '0;
            ll_q     <= '0;
            lr_q     <= '0;
            digest_q <= c_IV;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            j_q      <= j_d;
            x_q      <= x_d;
            c_q      <= c_d;
            ll_q     <= ll_d;
            lr_q     <= lr_d;
            digest_q <= digest_d;
            valid_q  <= valid_d;
        end
    end

    assign i_ready  = (state_q == ST_IDLE);
    assign o_valid  = valid_q;
    assign o_digest = digest_q;

endmodule
`default_nettype wire

// File: tb/tb_ripemd160_compress.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ripemd160_compress
// Description : Self-checking bench for ripemd160_compress. Known-answer
//               vectors plus random blocks against a whole-block reference
//               model; a side set of instances covers other UNROLL values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ripemd160_compress;

    localparam logic [159:0] IV  = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, 32'hc3d2e1f0};
    localparam logic [159:0] ABC = {32'hf708b28e, 32'h7a985de0, 32'h8e4a049b, 32'h87b0c698, 32'hfc0b5af1};
    localparam logic [159:0] FOX = {32'hf632f337, 32'hd97bb78d, 32'h96d4edd7, 32'h67ad7195, 32'h3bddf91c};
    localparam logic [159:0] L56 = {32'h3853a012, 32'h880c9c4a, 32'h6ca005e4, 32'h9af4dc27, 32'h2beb62da};

    localparam int RL[80] = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,
                              7,4,13,1,10,6,15,3,12,0,9,5,2,14,11,8,
                              3,10,14,4,9,15,8,1,2,7,0,6,13,11,5,12,
                              1,9,11,10,0,8,12,4,13,3,7,15,14,5,6,2,
                              4,0,5,9,7,12,2,10,14,1,3,8,11,6,15,13};
    localparam int RR[80] = '{5,14,7,0,9,2,11,4,13,6,15,8,1,10,3,12,
                              6,11,3,7,0,13,5,10,14,15,8,12,4,9,1,2,
                              15,5,1,3,7,14,6,9,11,8,12,2,10,0,4,13,
                              8,6,4,1,3,11,15,0,5,12,2,13,9,7,10,14,
                              12,15,10,4,1,5,8,7,6,2,13,14,0,3,9,11};
    localparam int SL[80] = '{11,14,15,12,5,8,7,9,11,13,14,15,6,7,9,8,
                              7,6,8,13,11,9,7,15,7,12,15,9,11,7,13,12,
                              11,13,6,7,14,9,13,15,14,8,13,6,5,12,7,5,
                              11,12,14,15,14,15,9,8,9,14,5,6,8,6,5,12,
                              9,15,5,11,6,8,13,12,5,12,13,14,11,8,5,6};
    localparam int SR[80] = '{8,9,9,11,13,15,15,5,7,7,8,11,14,14,12,6,
                              9,13,15,7,12,8,9,11,7,7,12,7,6,15,13,11,
                              9,7,15,11,8,6,6,14,12,13,5,14,13,13,7,5,
                              15,5,8,11,14,14,6,14,6,9,12,9,12,5,15,8,
                              8,5,12,9,12,5,14,6,8,13,6,5,15,13,11,11};
    localparam logic [31:0] KL[5] = '{32'h00000000, 32'h5a827999, 32'h6ed9eba1, 32'h8f1bbcdc, 32'ha953fd4e};
    localparam logic [31:0] KR[5] = '{32'h50a28be6, 32'h5c4dd124, 32'h6d703ef3, 32'h7a6d76e9, 32'h00000000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         i_valid, i_first, i_ready, o_valid;
    logic [511:0] i_block;
    logic [159:0] o_digest;

    logic [2:0]   sv, srdy, sov;
    logic         sfirst;
    logic [511:0] sblk;
    logic [159:0] sdig [3];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [159:0] exp_digest;

    always @(posedge clk) cyc <= cyc + 1;

    ripemd160_compress #(.UNROLL(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_first(i_first),
        .i_block(i_block), .o_valid(o_valid), .o_digest(o_digest));
    ripemd160_compress #(.UNROLL(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .i_valid(sv[0]), .i_ready(srdy[0]), .i_first(sfirst),
        .i_block(sblk), .o_valid(sov[0]), .o_digest(sdig[0]));
    ripemd160_compress #(.UNROLL(16)) u_s16 (
        .clk(clk), .rst_n(rst_n), .i_valid(sv[1]), .i_ready(srdy[1]), .i_first(sfirst),
        .i_block(sblk), .o_valid(sov[1]), .o_digest(sdig[1]));
    ripemd160_compress #(.UNROLL(20)) u_s20 (
        .clk(clk), .rst_n(rst_n), .i_valid(sv[2]), .i_ready(srdy[2]), .i_first(sfirst),
        .i_block(sblk), .o_valid(sov[2]), .o_digest(sdig[2]));

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_rol(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [31:0] m_f(input int r, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        case (r)
            0: return x ^ y ^ z;
            1: return (x & y) | (~x & z);
            2: return (x | ~y) ^ z;
            3: return (x & z) | (y & ~z);
            default: return x ^ (y | ~z);
        endcase
    endfunction

    function automatic logic [159:0] ref_compress(input logic [159:0] h, input logic [511:0] blk);
        logic [31:0] x [16];
        logic [31:0] hw [5];
        logic [31:0] al, bl, cl, dl, el, ar, br, cr, dr, er, t;
        for (int i = 0; i < 16; i++) x[i] = blk[32*i +: 32];
        for (int i = 0; i < 5; i++) hw[i] = h[159 - 32*i -: 32];
        al = hw[0]; bl = hw[1]; cl = hw[2]; dl = hw[3]; el = hw[4];
        ar = hw[0]; br = hw[1]; cr = hw[2]; dr = hw[3]; er = hw[4];
        for (int j = 0; j < 80; j++) begin
            t  = m_rol(al + m_f(j / 16, bl, cl, dl) + x[RL[j]] + KL[j / 16], SL[j]) + el;
            al = el; el = dl; dl = m_rol(cl, 10); cl = bl; bl = t;
            t  = m_rol(ar + m_f((79 - j) / 16, br, cr, dr) + x[RR[j]] + KR[j / 16], SR[j]) + er;
            ar = er; er = dr; dr = m_rol(cr, 10); cr = br; br = t;
        end
        return {hw[1] + cl + dr, hw[2] + dl + er, hw[3] + el + ar, hw[4] + al + br, hw[0] + bl + cr};
    endfunction

    // Pads a message (up to 119 bytes) and returns block number blk of it.
    function automatic logic [511:0] pad_msg(input string s, input int blk);
        logic [7:0]   p [128];
        logic [63:0]  bits;
        logic [511:0] out;
        int n, nb;
        n  = s.len();
        nb = (n + 9 + 63) / 64;
        for (int i = 0; i < 128; i++) p[i] = 8'h00;
        for (int i = 0; i < n; i++) p[i] = s[i];
        p[n] = 8'h80;
        bits = 64'(n) * 64'd8;
        for (int k = 0; k < 8; k++) p[nb*64 - 8 + k] = bits[8*k +: 8];
        for (int i = 0; i < 64; i++) out[8*i +: 8] = p[blk*64 + i];
        return out;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int k = 0; k < 16; k++) b[32*k +: 32] = $urandom;
        return b;
    endfunction

    // ---------------- drivers ----------------
    task automatic send_block(input logic [511:0] blk, input logic first, output int acc);
        int t = 0;
        while (!i_ready && t < 300) begin
            @(posedge clk); #1; t++;
        end
        if (!i_ready) begin
            checks++; errors++;
            $display("FAIL send_ready_timeout: i_ready=%0b required 1", i_ready);
        end
        i_valid = 1'b1; i_block = blk; i_first = first;
        @(posedge clk); #1;
        acc = cyc;
        i_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        int t = 0;
        dc = -1;
        while (t < 300) begin
            @(posedge clk); #1; t++;
            if (o_valid) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) begin
            checks++; errors++;
            $display("FAIL wait_done_timeout: o_valid never seen within %0d cycles", t);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", i_ready); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_digest !== IV) begin errors++; $display("FAIL reset_digest: got %h want %h", o_digest, IV); end
        checks++; if (srdy !== 3'b111) begin errors++; $display("FAIL reset_sweep_ready: got %b want 111", srdy); end
    endtask

    task automatic test_abc();
        int acc, dc;
        logic [511:0] b;
        b = pad_msg("abc", 0);
        checks++; if (b[31:0] !== 32'h80636261 || b[479:448] !== 32'h18) begin
            errors++; $display("FAIL abc_pad: got %h %h want 80636261 00000018", b[31:0], b[479:448]);
        end
        send_block(b, 1'b1, acc);
        wait_done(dc);
        checks++; if (dc - acc != 80) begin errors++; $display("FAIL abc_latency: got %0d want 80", dc - acc); end
        checks++; if (o_digest !== ABC) begin errors++; $display("FAIL abc_digest: got %h want %h", o_digest, ABC); end
        checks++; if (o_digest !== ref_compress(IV, b)) begin errors++; $display("FAIL abc_model: got %h want %h", o_digest, ref_compress(IV, b)); end
        exp_digest = ABC;
        @(posedge clk); #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL abc_pulse_width: got %b want 0", o_valid); end
        checks++; if (o_digest !== ABC) begin errors++; $display("FAIL abc_hold: got %h want %h", o_digest, ABC); end
    endtask

    task automatic test_fox();
        int acc, dc;
        send_block(pad_msg("The quick brown fox jumps over the lazy dog", 0), 1'b1, acc);
        wait_done(dc);
        checks++; if (o_digest !== FOX) begin errors++; $display("FAIL fox_digest: got %h want %h", o_digest, FOX); end
        exp_digest = FOX;
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, dc;
        string m;
        m = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        send_block(pad_msg(m, 0), 1'b1, acc1);
        wait_done(dc);
        checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_valid_cycle: got %b want 1", i_ready); end
        send_block(pad_msg(m, 1), 1'b0, acc2);
        checks++; if (acc2 - acc1 != 81) begin errors++; $display("FAIL b2b_gap: got %0d want 81", acc2 - acc1); end
        wait_done(dc);
        checks++; if (o_digest !== L56) begin errors++; $display("FAIL b2b_digest: got %h want %h", o_digest, L56); end
        exp_digest = L56;
    endtask

    task automatic test_unroll_sweep();
        int acc;
        int lat [3];
        int want [3];
        want = '{20, 5, 4};
        lat  = '{-1, -1, -1};
        sblk = pad_msg("abc", 0); sfirst = 1'b1; sv = 3'b111;
        @(posedge clk); #1;
        acc = cyc; sv = 3'b000;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++)
                if (sov[k] && lat[k] < 0) lat[k] = cyc - acc;
        end
        for (int k = 0; k < 3; k++) begin
            checks++; if (lat[k] != want[k]) begin errors++; $display("FAIL sweep_latency[%0d]: got %0d want %0d", k, lat[k], want[k]); end
            checks++; if (sdig[k] !== ABC) begin errors++; $display("FAIL sweep_digest[%0d]: got %h want %h", k, sdig[k], ABC); end
        end
    endtask

    task automatic test_busy_ignore();
        int acc, dc;
        logic bad_ready;
        logic [511:0] a, b;
        a = rand_block();
        while (!i_ready) begin @(posedge clk); #1; end
        i_valid = 1'b1; i_block = a; i_first = 1'b1;
        @(posedge clk); #1;
        acc = cyc; dc = -1; bad_ready = 1'b0;
        for (int t = 0; t < 200; t++) begin
            i_block = rand_block(); i_first = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (o_valid) begin dc = cyc; break; end
            bad_ready |= i_ready;
        end
        checks++; if (dc - acc != 80) begin errors++; $display("FAIL busy_latency: got %0d want 80", dc - acc); end
        checks++; if (bad_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", bad_ready); end
        checks++; if (o_digest !== ref_compress(IV, a)) begin errors++; $display("FAIL busy_digest: got %h want %h", o_digest, ref_compress(IV, a)); end
        b = rand_block();
        i_block = b; i_first = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL busy_accept_first_idle: got ready %b want 0", i_ready); end
        i_valid = 1'b0;
        wait_done(dc);
        checks++; if (o_digest !== ref_compress(IV, b)) begin errors++; $display("FAIL busy_second: got %h want %h", o_digest, ref_compress(IV, b)); end
        exp_digest = ref_compress(IV, b);
    endtask

    task automatic test_reset_mid();
        int acc, dc;
        send_block(pad_msg("abc", 0), 1'b1, acc);
        repeat (40) @(posedge clk);
        #2 rst_n = 1'b0;
        #2;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", o_valid); end
        checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", i_ready); end
        checks++; if (o_digest !== IV) begin errors++; $display("FAIL rstmid_digest: got %h want %h", o_digest, IV); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        checks++; if (o_digest !== IV) begin errors++; $display("FAIL rstmid_no_result: got %h want %h", o_digest, IV); end
        send_block(pad_msg("abc", 0), 1'b0, acc);
        wait_done(dc);
        checks++; if (o_digest !== ABC) begin errors++; $display("FAIL rstmid_abc_chain_iv: got %h want %h", o_digest, ABC); end
        exp_digest = ABC;
    endtask

    task automatic test_random();
        int acc, dc;
        logic [511:0] b;
        logic f;
        for (int n = 0; n < 8; n++) begin
            b = rand_block();
            f = 1'($urandom_range(0, 1));
            exp_digest = ref_compress(f ? IV : exp_digest, b);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send_block(b, f, acc);
            wait_done(dc);
            checks++; if (dc - acc != 80) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want 80", n, dc - acc); end
            checks++; if (o_digest !== exp_digest) begin errors++; $display("FAIL rand_digest[%0d] first=%0b: got %h want %h", n, f, o_digest, exp_digest); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_first = 1'b0; i_block = '0;
        sv = 3'b000; sfirst = 1'b0; sblk = '0;
        exp_digest = IV;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_abc();
        test_fox();
        test_back_to_back();
        test_unroll_sweep();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
